// File: rtl/dg_sched.sv
// Multi-source header scheduler: arbitrates NUM_SRC FWFT header FIFOs
// (priority-first, round-robin on ties) and feeds one data_gen over valid/ready.
module dg_sched #(
  parameter int NUM_SRC   = 4,
  parameter int GEN_INF_W = 32,
  parameter int PRIO_EN   = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_SRC-1:0]             i_fifo_ready,
  input  logic [NUM_SRC*GEN_INF_W-1:0]   i_fifo_data,
  output logic [NUM_SRC-1:0]             o_fifo_rden,
  input  logic                           i_dg_ready,
  output logic [3:0]                     o_da,
  output logic [2:0]                     o_prior,
  output logic [9:0]                     o_len,
  output logic                           o_vld,
  output logic [NUM_SRC-1:0]             o_grant,
  output logic                           o_drop
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     gnt_idx;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W-1:0]     scan_idx;
  logic                 win_vld;
  logic [NUM_SRC-1:0]   win_oh;
  logic [NUM_SRC-1:0]   elig;
  logic [2:0]           max_prior;
  logic [3:0]           win_da;
  logic [2:0]           win_prior;
  logic [9:0]           win_len;

  // Header bits above the len field carry nothing for the scheduler.
  logic unused_hdr_bits;
  assign unused_hdr_bits = ^i_fifo_data;

  always_comb begin
    max_prior = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (i_fifo_ready[k] && (i_fifo_data[k*GEN_INF_W+4 +: 3] > max_prior))
        max_prior = i_fifo_data[k*GEN_INF_W+4 +: 3];
    end
    elig = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      elig[k] = i_fifo_ready[k] &&
                ((PRIO_EN == 0) || (i_fifo_data[k*GEN_INF_W+4 +: 3] == max_prior));
    end
    // Rotating scan starting just after the last served source.
    win_vld  = 1'b0;
    win_idx  = '0;
    scan_idx = '0;
    for (int unsigned off = 1; off <= NUM_SRC; off++) begin
      scan_idx = IDX_W'((32'(rr_ptr) + off) % 32'(NUM_SRC));
      if (!win_vld && elig[scan_idx]) begin
        win_vld = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  always_comb begin
    win_da    = i_fifo_data[32'(win_idx)*GEN_INF_W     +: 4];
    win_prior = i_fifo_data[32'(win_idx)*GEN_INF_W + 4 +: 3];
    win_len   = i_fifo_data[32'(win_idx)*GEN_INF_W + 7 +: 10];
    win_oh    = '0;
    if (win_vld)
      win_oh[win_idx] = 1'b1;
  end

  always_comb begin
    o_fifo_rden = '0;
    if (state == IDLE && !rst)
      o_fifo_rden = win_oh;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (win_vld && win_len != '0) state_nxt = ISSUE;
      ISSUE: if (i_dg_ready)               state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_da    <= '0;
      o_prior <= '0;
      o_len   <= '0;
      o_vld   <= 1'b0;
      o_grant <= '0;
      o_drop  <= 1'b0;
      gnt_idx <= '0;
      rr_ptr  <= IDX_W'(NUM_SRC - 1);
    end else begin
      o_drop <= 1'b0;
      unique case (state)
        IDLE: begin
          o_vld   <= 1'b0;
          o_grant <= '0;
          if (win_vld) begin
            if (win_len != '0) begin
              o_da    <= win_da;
              o_prior <= win_prior;
              o_len   <= win_len;
              o_grant <= win_oh;
              o_vld   <= 1'b1;
              gnt_idx <= win_idx;
            end else begin
              o_drop <= 1'b1;
              rr_ptr <= win_idx;
            end
          end
        end
        ISSUE: begin
          if (i_dg_ready) begin
            o_vld   <= 1'b0;
            o_grant <= '0;
            rr_ptr  <= gnt_idx;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dg_sched.sv
// Scoreboard bench for dg_sched: a PRIO_EN=1 and a PRIO_EN=0 instance, each
// fed by its own behavioural FWFT FIFO model.
module tb_dg_sched;

  localparam int NS = 4;
  localparam int W  = 32;

  typedef struct {
    bit         drop;
    logic [3:0] grant;
    logic [3:0] da;
    logic [2:0] prior;
    logic [9:0] len;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NS-1:0]   a_fifo_ready, b_fifo_ready;
  logic [NS*W-1:0] a_fifo_data,  b_fifo_data;
  logic [NS-1:0]   a_rden, b_rden;
  logic            a_dg_ready, b_dg_ready;
  logic [3:0]      a_da, b_da;
  logic [2:0]      a_prior, b_prior;
  logic [9:0]      a_len, b_len;
  logic            a_vld, b_vld;
  logic [NS-1:0]   a_grant, b_grant;
  logic            a_drop, b_drop;

  dg_sched #(.NUM_SRC(NS), .GEN_INF_W(W), .PRIO_EN(1)) dut_a (
    .clk(clk), .rst(rst), .i_fifo_ready(a_fifo_ready), .i_fifo_data(a_fifo_data),
    .o_fifo_rden(a_rden), .i_dg_ready(a_dg_ready), .o_da(a_da), .o_prior(a_prior),
    .o_len(a_len), .o_vld(a_vld), .o_grant(a_grant), .o_drop(a_drop));

  dg_sched #(.NUM_SRC(NS), .GEN_INF_W(W), .PRIO_EN(0)) dut_b (
    .clk(clk), .rst(rst), .i_fifo_ready(b_fifo_ready), .i_fifo_data(b_fifo_data),
    .o_fifo_rden(b_rden), .i_dg_ready(b_dg_ready), .o_da(b_da), .o_prior(b_prior),
    .o_len(b_len), .o_vld(b_vld), .o_grant(b_grant), .o_drop(b_drop));

  logic [31:0] fqa [NS][$];
  logic [31:0] fqb [NS][$];
  exp_t        sba [$];
  exp_t        sbb [$];
  int          pops_a [NS];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] hdr(input int da, input int pr, input int ln);
    return {15'h2B5A, 10'(ln), 3'(pr), 4'(da)};
  endfunction

  function automatic exp_t mk(input bit drop, input int k, input int da, input int pr, input int ln);
    exp_t e;
    e.drop  = drop;
    e.grant = 4'(1 << k);
    e.da    = 4'(da);
    e.prior = 3'(pr);
    e.len   = 10'(ln);
    return e;
  endfunction

  task automatic refresh();
    for (int k = 0; k < NS; k++) begin
      a_fifo_ready[k]       = (fqa[k].size() != 0);
      a_fifo_data[k*W +: W] = (fqa[k].size() != 0) ? fqa[k][0] : 32'hFFFF_FF80;
      b_fifo_ready[k]       = (fqb[k].size() != 0);
      b_fifo_data[k*W +: W] = (fqb[k].size() != 0) ? fqb[k][0] : 32'hFFFF_FF80;
    end
  endtask

  task automatic push_a(input int k, input logic [31:0] w);
    fqa[k].push_back(w);
    refresh();
  endtask

  task automatic push_b(input int k, input logic [31:0] w);
    fqb[k].push_back(w);
    refresh();
  endtask

  task automatic mon_dut(input string nm, input bit is_b, input logic vld, input logic rdy,
                         input logic drop, input logic [3:0] grant, input logic [3:0] da,
                         input logic [2:0] pr, input logic [9:0] ln,
                         input logic [3:0] rden, input logic [3:0] fready);
    exp_t e;
    if ((vld && rdy) || drop) begin
      if ((is_b ? sbb.size() : sba.size()) == 0) begin
        check({nm, "_unexpected_out"}, 1, 0);
      end else begin
        if (is_b) e = sbb.pop_front();
        else      e = sba.pop_front();
        check({nm, "_kind_drop"}, 32'(drop), 32'(e.drop));
        if (!e.drop) begin
          check({nm, "_grant"}, 32'(grant), 32'(e.grant));
          check({nm, "_da"},    32'(da),    32'(e.da));
          check({nm, "_prior"}, 32'(pr),    32'(e.prior));
          check({nm, "_len"},   32'(ln),    32'(e.len));
        end
      end
    end
    check({nm, "_rden_legal"},
          32'(((rden & (rden - 4'd1)) == 4'd0) && ((rden & ~fready) == 4'd0)), 1);
  endtask

  // One clock: observe mid-cycle, latch pops seen before the edge, apply them after it.
  task automatic step();
    logic [NS-1:0] pend_a, pend_b;
    #1;
    mon_dut("A", 1'b0, a_vld, a_dg_ready, a_drop, a_grant, a_da, a_prior, a_len, a_rden, a_fifo_ready);
    mon_dut("B", 1'b1, b_vld, b_dg_ready, b_drop, b_grant, b_da, b_prior, b_len, b_rden, b_fifo_ready);
    pend_a = a_rden;
    pend_b = b_rden;
    @(posedge clk);
    #1;
    for (int k = 0; k < NS; k++) begin
      if (pend_a[k] && fqa[k].size() != 0) begin
        void'(fqa[k].pop_front());
        pops_a[k]++;
      end
      if (pend_b[k] && fqb[k].size() != 0)
        void'(fqb[k].pop_front());
    end
    refresh();
    @(negedge clk);
  endtask

  task automatic drain(input string tag, input int max_cyc);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (sba.size() == 0 && sbb.size() == 0 && !a_vld && !b_vld && a_fifo_ready == '0 &&
          b_fifo_ready == '0) begin
        done = 1'b1;
        break;
      end
      step();
    end
    check({tag, "_drain_in_budget"}, 32'(done), 1);
  endtask

  task automatic clear_all();
    for (int k = 0; k < NS; k++) begin
      fqa[k].delete();
      fqb[k].delete();
      pops_a[k] = 0;
    end
    sba.delete();
    sbb.delete();
    refresh();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_all();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_dg_ready = 1'b1;
    b_dg_ready = 1'b1;
    clear_all();
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_vld",   32'(a_vld),   0);
    check("rst_grant", 32'(a_grant), 0);
    check("rst_drop",  32'(a_drop),  0);
    check("rst_fields", {15'd0, a_len, a_prior, a_da}, 0);
    push_a(0, hdr(1, 1, 1));
    #1;
    check("rst_no_pop", 32'(a_rden), 0);
    clear_all();
    @(negedge clk);
    rst = 1'b0;

    // Single source
    push_a(0, hdr(5, 2, 64));
    sba.push_back(mk(0, 0, 5, 2, 64));
    #1;
    check("t1_rden", 32'(a_rden), 32'b0001);
    step();
    check("t1_vld",   32'(a_vld),   1);
    check("t1_da",    32'(a_da),    5);
    check("t1_prior", 32'(a_prior), 2);
    check("t1_len",   32'(a_len),   64);
    check("t1_grant", 32'(a_grant), 32'b0001);
    check("t1_rden_issue", 32'(a_rden), 0);
    step();
    check("t1_vld_low", 32'(a_vld), 0);
    check("t1_pops", 32'(pops_a[0]), 1);

    // Round-robin among equal priorities, one transfer per two cycles
    do_reset();
    for (int j = 0; j < 2; j++)
      for (int k = 0; k < NS; k++) begin
        push_a(k, hdr(k + 4*j, 3, 10 + k + 4*j));
        sba.push_back(mk(0, k, k + 4*j, 3, 10 + k + 4*j));
      end
    repeat (15) step();
    check("t2_one_left", 32'(sba.size()), 1);
    step();
    check("t2_all_done", 32'(sba.size()), 0);
    check("t2_vld_idle", 32'(a_vld), 0);

    // Priority (A) versus pure rotation (B)
    do_reset();
    for (int j = 0; j < 3; j++) begin
      push_a(1, hdr(8 + j, 7, 100 + j));
      push_b(1, hdr(8 + j, 7, 100 + j));
    end
    for (int j = 0; j < 2; j++)
      for (int k = 0; k < NS; k++)
        if (k != 1) begin
          push_a(k, hdr(k + 4*j, 1, 200 + 10*k + j));
          push_b(k, hdr(k + 4*j, 1, 200 + 10*k + j));
        end
    for (int j = 0; j < 3; j++) sba.push_back(mk(0, 1, 8 + j, 7, 100 + j));
    for (int j = 0; j < 2; j++) begin
      sba.push_back(mk(0, 2, 2 + 4*j, 1, 220 + j));
      sba.push_back(mk(0, 3, 3 + 4*j, 1, 230 + j));
      sba.push_back(mk(0, 0, 0 + 4*j, 1, 200 + j));
    end
    for (int j = 0; j < 2; j++) begin
      sbb.push_back(mk(0, 0, 0 + 4*j, 1, 200 + j));
      sbb.push_back(mk(0, 1, 8 + j,   7, 100 + j));
      sbb.push_back(mk(0, 2, 2 + 4*j, 1, 220 + j));
      sbb.push_back(mk(0, 3, 3 + 4*j, 1, 230 + j));
    end
    sbb.push_back(mk(0, 1, 10, 7, 102));
    drain("t3", 60);

    // Backpressure: hold for 10 cycles, inputs changing underneath
    for (int k = 0; k < NS; k++) pops_a[k] = 0;
    a_dg_ready = 1'b0;
    push_a(3, hdr(9, 4, 100));
    sba.push_back(mk(0, 3, 9, 4, 100));
    step();
    check("bp_vld_rise", 32'(a_vld), 1);
    push_a(1, hdr(2, 6, 33));
    sba.push_back(mk(0, 1, 2, 6, 33));
    for (int i = 0; i < 10; i++) begin
      check("bp_vld",   32'(a_vld),   1);
      check("bp_hold",  {15'd0, a_len, a_prior, a_da}, {15'd0, 10'd100, 3'd4, 4'd9});
      check("bp_grant", 32'(a_grant), 32'b1000);
      check("bp_no_rden", 32'(a_rden), 0);
      step();
    end
    a_dg_ready = 1'b1;
    step();
    check("bp_vld_fall", 32'(a_vld), 0);
    check("bp_src1_unpopped", 32'(pops_a[1]), 0);
    drain("t4", 20);

    // Zero-length header is dropped, next header issues
    for (int k = 0; k < NS; k++) pops_a[k] = 0;
    push_a(2, hdr(7, 1, 0));
    push_a(2, hdr(6, 1, 8));
    sba.push_back(mk(1, 2, 0, 0, 0));
    sba.push_back(mk(0, 2, 6, 1, 8));
    drain("t5", 20);
    check("t5_pops", 32'(pops_a[2]), 2);

    // Reset while issuing
    for (int k = 0; k < NS; k++) pops_a[k] = 0;
    a_dg_ready = 1'b0;
    for (int k = 0; k < NS; k++) push_a(k, hdr(k, 5, 40 + k));
    step();
    check("t6_pre_vld",   32'(a_vld),   1);
    check("t6_pre_grant", 32'(a_grant), 32'b1000);
    rst = 1'b1;
    #1;
    check("t6_rst_vld",   32'(a_vld),   0);
    check("t6_rst_grant", 32'(a_grant), 0);
    check("t6_rst_rden",  32'(a_rden),  0);
    step();
    check("t6_no_pop_in_rst", 32'(pops_a[0] + pops_a[1] + pops_a[2] + pops_a[3]), 1);
    clear_all();
    rst = 1'b0;
    a_dg_ready = 1'b1;
    for (int k = 0; k < NS; k++) begin
      push_a(k, hdr(k, 5, 50 + k));
      sba.push_back(mk(0, k, k, 5, 50 + k));
    end
    drain("t6", 30);

    check("final_sb_a_empty", 32'(sba.size()), 0);
    check("final_sb_b_empty", 32'(sbb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
